// File: rtl/mont_wrapper_pkg.sv
// Shared definitions for the Montgomery command wrapper: opcodes, error codes,
// command-word field positions, FSM state encoding and an index range helper.
package mont_wrapper_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_CLEAR = 4'd4;

  localparam logic [3:0] ERR_NONE    = 4'd0;
  localparam logic [3:0] ERR_OPCODE  = 4'd1;
  localparam logic [3:0] ERR_INDEX   = 4'd2;
  localparam logic [3:0] ERR_TIMEOUT = 4'd3;

  // Command word: op[3:0] dst[7:4] srcA[11:8] srcB[15:12] srcM[19:16]
  localparam int FIELD_W  = 4;
  localparam int OP_LSB   = 0;
  localparam int DST_LSB  = 4;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_LSB = 12;
  localparam int SRCM_LSB = 16;

  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_START, S_WAIT, S_WRBACK, S_CLEAR, S_DONE
  } state_t;

  function automatic logic idx_ok(input logic [3:0] idx, input int num_regs);
    return int'(idx) < num_regs;
  endfunction

endpackage

// File: rtl/mont_reg_file.sv
// Operand register file: NUM_REGS x OP_WIDTH, async reset to zero.
// Ports: one BEAT-wide write port and one BEAT-wide read port whose slice k
// addresses entry (base+k) mod NUM_REGS; three operand read ports; one
// single-entry write port for core results.
module mont_reg_file #(
  parameter int OP_WIDTH = 512,
  parameter int NUM_REGS = 8,
  parameter int BEAT     = 2,
  parameter int IW       = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          beat_we,
  input  logic [IW-1:0]                 beat_widx,
  input  logic [BEAT-1:0][OP_WIDTH-1:0] beat_wdata,
  input  logic [IW-1:0]                 beat_ridx,
  output logic [BEAT-1:0][OP_WIDTH-1:0] beat_rdata,
  input  logic                          one_we,
  input  logic [IW-1:0]                 one_widx,
  input  logic [OP_WIDTH-1:0]           one_wdata,
  input  logic [IW-1:0]                 ra,
  input  logic [IW-1:0]                 rb,
  input  logic [IW-1:0]                 rm,
  output logic [OP_WIDTH-1:0]           rd_a,
  output logic [OP_WIDTH-1:0]           rd_b,
  output logic [OP_WIDTH-1:0]           rd_m
);

  logic [NUM_REGS-1:0][OP_WIDTH-1:0] regs;

  // NUM_REGS is a power of two, so IW-bit index arithmetic wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      if (beat_we)
        for (int k = 0; k < BEAT; k++)
          regs[beat_widx + IW'(k)] <= beat_wdata[k];
      if (one_we)
        regs[one_widx] <= one_wdata;
    end
  end

  for (genvar k = 0; k < BEAT; k++) begin : g_rd
    assign beat_rdata[k] = regs[beat_ridx + IW'(k)];
  end

  assign rd_a = regs[ra];
  assign rd_b = regs[rb];
  assign rd_m = regs[rm];

endmodule

// File: rtl/mont_cmd_wrapper.sv
// Host command/data front end for one Montgomery multiplier core.
// Host side: 32-bit command + done/done_read handshake, TX_SIZE-wide
// valid/ready data in and out, 32-bit status {err[3:0], 4'b0, cycles[23:0]}.
// Core side: registered start pulse and operands, result/done in, core_clear
// soft reset (also held high while reset is asserted). leds = {err!=0, state}.
module mont_cmd_wrapper
  import mont_wrapper_pkg::*;
#(
  parameter int TX_SIZE        = 1024,
  parameter int OP_WIDTH       = 512,
  parameter int NUM_REGS       = 8,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         arm_to_fpga_cmd,
  input  logic                arm_to_fpga_cmd_valid,
  output logic                fpga_to_arm_done,
  input  logic                fpga_to_arm_done_read,
  input  logic                arm_to_fpga_data_valid,
  output logic                arm_to_fpga_data_ready,
  input  logic [TX_SIZE-1:0]  arm_to_fpga_data,
  output logic                fpga_to_arm_data_valid,
  input  logic                fpga_to_arm_data_ready,
  output logic [TX_SIZE-1:0]  fpga_to_arm_data,
  output logic [31:0]         fpga_to_arm_status,
  output logic                core_start,
  output logic [OP_WIDTH-1:0] core_a,
  output logic [OP_WIDTH-1:0] core_b,
  output logic [OP_WIDTH-1:0] core_m,
  input  logic [OP_WIDTH-1:0] core_result,
  input  logic                core_done,
  output logic                core_clear,
  output logic [3:0]          leds
);

  localparam int BEAT = TX_SIZE / OP_WIDTH;
  localparam int IW   = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t            state;
  logic [3:0]        err;
  logic [IW-1:0]     dst_r;
  logic [CNT_W-1:0]  cnt, cnt_nx, cnt_rec;
  logic              clr_r;

  logic [3:0] c_op, c_dst, c_a, c_b, c_m;
  assign c_op  = arm_to_fpga_cmd[OP_LSB   +: FIELD_W];
  assign c_dst = arm_to_fpga_cmd[DST_LSB  +: FIELD_W];
  assign c_a   = arm_to_fpga_cmd[SRCA_LSB +: FIELD_W];
  assign c_b   = arm_to_fpga_cmd[SRCB_LSB +: FIELD_W];
  assign c_m   = arm_to_fpga_cmd[SRCM_LSB +: FIELD_W];

  logic unused_cmd;
  assign unused_cmd = ^arm_to_fpga_cmd[31:20];

  logic bad_idx;
  always_comb begin
    bad_idx = 1'b0;
    if (c_op == OP_LOAD || c_op == OP_STORE)
      bad_idx = !idx_ok(c_dst, NUM_REGS);
    else if (c_op == OP_MULT)
      bad_idx = !(idx_ok(c_dst, NUM_REGS) && idx_ok(c_a, NUM_REGS) &&
                  idx_ok(c_b, NUM_REGS) && idx_ok(c_m, NUM_REGS));
  end

  logic [OP_WIDTH-1:0] rd_a, rd_b, rd_m;
  logic [TX_SIZE-1:0]  rd_beat;
  logic                beat_we, res_we;

  assign beat_we = (state == S_LOAD) && arm_to_fpga_data_valid;
  // The result is committed on the core_done edge, so it is in place as the
  // FSM sits in WRBACK; a core_done outside WAIT never writes.
  assign res_we  = (state == S_WAIT) && core_done;

  mont_reg_file #(
    .OP_WIDTH(OP_WIDTH), .NUM_REGS(NUM_REGS), .BEAT(BEAT), .IW(IW)
  ) u_rf (
    .clk(clk), .reset(reset),
    .beat_we(beat_we), .beat_widx(dst_r), .beat_wdata(arm_to_fpga_data),
    .beat_ridx(c_dst[IW-1:0]), .beat_rdata(rd_beat),
    .one_we(res_we), .one_widx(dst_r), .one_wdata(core_result),
    .ra(c_a[IW-1:0]), .rb(c_b[IW-1:0]), .rm(c_m[IW-1:0]),
    .rd_a(rd_a), .rd_b(rd_b), .rd_m(rd_m)
  );

  // cnt counts completed WAIT cycles; cnt_nx is the count including this one.
  assign cnt_nx = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      err              <= ERR_NONE;
      dst_r            <= '0;
      cnt              <= '0;
      cnt_rec          <= '0;
      clr_r            <= 1'b0;
      fpga_to_arm_done <= 1'b0;
      core_start       <= 1'b0;
      core_a           <= '0;
      core_b           <= '0;
      core_m           <= '0;
      fpga_to_arm_data <= '0;
    end else begin
      core_start <= 1'b0;
      clr_r      <= 1'b0;
      case (state)
        S_IDLE: if (arm_to_fpga_cmd_valid) begin
          err   <= ERR_NONE;
          dst_r <= c_dst[IW-1:0];
          if (c_op > OP_CLEAR) begin
            err <= ERR_OPCODE; state <= S_DONE; fpga_to_arm_done <= 1'b1;
          end else if (bad_idx) begin
            err <= ERR_INDEX;  state <= S_DONE; fpga_to_arm_done <= 1'b1;
          end else begin
            case (c_op)
              OP_LOAD:  state <= S_LOAD;
              OP_STORE: begin
                state            <= S_STORE;
                fpga_to_arm_data <= rd_beat;
              end
              OP_MULT: begin
                state      <= S_START;
                core_start <= 1'b1;
                core_a     <= rd_a;
                core_b     <= rd_b;
                core_m     <= rd_m;
                cnt        <= '0;
              end
              OP_CLEAR: begin
                state <= S_CLEAR;
                clr_r <= 1'b1;
              end
              default: begin
                state <= S_DONE; fpga_to_arm_done <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD: if (arm_to_fpga_data_valid) begin
          state <= S_DONE; fpga_to_arm_done <= 1'b1;
        end
        S_STORE: if (fpga_to_arm_data_ready) begin
          state <= S_DONE; fpga_to_arm_done <= 1'b1;
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            cnt_rec <= cnt_nx;
            state   <= S_WRBACK;
          end else if (cnt_nx >= TO_LIM) begin
            cnt_rec <= cnt_nx;
            err     <= ERR_TIMEOUT;
            clr_r   <= 1'b1;
            state   <= S_DONE; fpga_to_arm_done <= 1'b1;
          end else begin
            cnt <= cnt_nx;
          end
        end
        S_WRBACK, S_CLEAR: begin
          state <= S_DONE; fpga_to_arm_done <= 1'b1;
        end
        S_DONE: if (fpga_to_arm_done_read) begin
          state <= S_IDLE; fpga_to_arm_done <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign arm_to_fpga_data_ready = (state == S_LOAD);
  assign fpga_to_arm_data_valid = (state == S_STORE);
  assign core_clear             = clr_r | reset;
  assign fpga_to_arm_status     = {err, 4'b0, cnt_rec};
  assign leds                   = {err != ERR_NONE, state};

endmodule

// File: tb/tb_mont_cmd_wrapper.sv
// Self-checking bench for mont_cmd_wrapper: a transaction-level model (register
// array, expected error/count) drives per-cycle expectations that a single
// negedge monitor compares against the DUT outputs.
module tb_mont_cmd_wrapper;
  localparam int TX = 1024, OPW = 512, NR = 8, TO = 64;

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] arm_to_fpga_cmd = '0;
  logic arm_to_fpga_cmd_valid = 1'b0, fpga_to_arm_done, fpga_to_arm_done_read = 1'b0;
  logic arm_to_fpga_data_valid = 1'b0, arm_to_fpga_data_ready;
  logic [TX-1:0] arm_to_fpga_data = '0, fpga_to_arm_data;
  logic fpga_to_arm_data_valid, fpga_to_arm_data_ready = 1'b0;
  logic [31:0] fpga_to_arm_status;
  logic core_start, core_clear, core_done = 1'b0;
  logic [OPW-1:0] core_a, core_b, core_m, core_result = '0;
  logic [3:0] leds;

  mont_cmd_wrapper #(.TX_SIZE(TX), .OP_WIDTH(OPW), .NUM_REGS(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .arm_to_fpga_cmd(arm_to_fpga_cmd), .arm_to_fpga_cmd_valid(arm_to_fpga_cmd_valid),
    .fpga_to_arm_done(fpga_to_arm_done), .fpga_to_arm_done_read(fpga_to_arm_done_read),
    .arm_to_fpga_data_valid(arm_to_fpga_data_valid), .arm_to_fpga_data_ready(arm_to_fpga_data_ready),
    .arm_to_fpga_data(arm_to_fpga_data),
    .fpga_to_arm_data_valid(fpga_to_arm_data_valid), .fpga_to_arm_data_ready(fpga_to_arm_data_ready),
    .fpga_to_arm_data(fpga_to_arm_data), .fpga_to_arm_status(fpga_to_arm_status),
    .core_start(core_start), .core_a(core_a), .core_b(core_b), .core_m(core_m),
    .core_result(core_result), .core_done(core_done), .core_clear(core_clear), .leds(leds)
  );

  always #5 clk = ~clk;

  // Model state
  logic [OPW-1:0] regs_m [NR];
  logic [3:0]     exp_err = '0;
  logic [23:0]    exp_cnt = '0;
  logic exp_done = 0, exp_ready = 0, exp_dvalid = 0, exp_start = 0, exp_clear = 1, ops_on = 0;
  logic [TX-1:0]  exp_data = '0;
  logic [OPW-1:0] exp_a = '0, exp_b = '0, exp_m = '0;
  logic           mon_en = 0, lit_en = 0;
  logic [TX-1:0]  lit_data = '0;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [TX-1:0] act, input logic [TX-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (low 128 bits)", nm, act[127:0], exp[127:0]);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("done",      TX'(fpga_to_arm_done),       TX'(exp_done));
    chk("ready",     TX'(arm_to_fpga_data_ready), TX'(exp_ready));
    chk("dvalid",    TX'(fpga_to_arm_data_valid), TX'(exp_dvalid));
    chk("core_start",TX'(core_start),             TX'(exp_start));
    chk("core_clear",TX'(core_clear),             TX'(exp_clear));
    chk("status",    TX'(fpga_to_arm_status),     TX'({exp_err, 4'b0, exp_cnt}));
    chk("led_err",   TX'(leds[3]),                TX'(exp_err != 4'd0));
    if (exp_dvalid) chk("store_data", fpga_to_arm_data, exp_data);
    if (ops_on) begin
      chk("core_a", TX'(core_a), TX'(exp_a));
      chk("core_b", TX'(core_b), TX'(exp_b));
      chk("core_m", TX'(core_m), TX'(exp_m));
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  function automatic logic [OPW-1:0] rnd512();
    logic [OPW-1:0] v;
    for (int i = 0; i < OPW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic finish_done();
    repeat ($urandom_range(0, 3)) begin
      if ($urandom_range(0, 1) == 1) arm_to_fpga_cmd_valid = 1'b1;  // ignored in DONE
      tick();
      arm_to_fpga_cmd_valid = 1'b0;
    end
    fpga_to_arm_done_read = 1'b1;
    tick();
    fpga_to_arm_done_read = 1'b0;
    exp_done = 0;
    if ($urandom_range(0, 1) == 1) begin  // stray done_read in IDLE
      fpga_to_arm_done_read = 1'b1; tick(); fpga_to_arm_done_read = 1'b0;
    end
  endtask

  // lat: MULT core latency in cycles after start (0 = core never answers).
  // ld: LOAD beat, or MULT result in its low OPW bits.
  task automatic run_cmd(input logic [3:0] op, d, a, b, m, input int lat, input logic [TX-1:0] ld);
    logic bad;
    bad = ((op == 1 || op == 2 || op == 3) && d >= 8) || (op == 3 && (a >= 8 || b >= 8 || m >= 8));
    arm_to_fpga_cmd = {12'($urandom), m, b, a, d, op};
    arm_to_fpga_cmd_valid = 1'b1;
    tick();
    arm_to_fpga_cmd_valid = 1'b0;
    arm_to_fpga_cmd = $urandom;
    exp_err = 0;
    if (op > 4) begin exp_err = 1; exp_done = 1; end
    else if (bad) begin exp_err = 2; exp_done = 1; end
    else case (op)
      4'd0: exp_done = 1;
      4'd1: begin
        exp_ready = 1;
        repeat ($urandom_range(0, 3)) begin
          arm_to_fpga_data = {rnd512(), rnd512()};
          if ($urandom_range(0, 1) == 1) arm_to_fpga_cmd_valid = 1'b1;  // ignored in LOAD
          tick();
          arm_to_fpga_cmd_valid = 1'b0;
        end
        arm_to_fpga_data = ld; arm_to_fpga_data_valid = 1'b1;
        tick();
        arm_to_fpga_data_valid = 1'b0; arm_to_fpga_data = {rnd512(), rnd512()};
        exp_ready = 0; exp_done = 1;
        for (int k = 0; k < TX/OPW; k++) regs_m[(int'(d) + k) % NR] = ld[k*OPW +: OPW];
      end
      4'd2: begin
        exp_dvalid = 1;
        for (int k = 0; k < TX/OPW; k++) exp_data[k*OPW +: OPW] = regs_m[(int'(d) + k) % NR];
        if (lit_en) chk("store_literal", fpga_to_arm_data, lit_data);
        repeat ($urandom_range(0, 3)) tick();
        fpga_to_arm_data_ready = 1'b1;
        tick();
        fpga_to_arm_data_ready = 1'b0;
        exp_dvalid = 0; exp_done = 1;
      end
      4'd3: begin
        exp_start = 1; ops_on = 1;
        exp_a = regs_m[a]; exp_b = regs_m[b]; exp_m = regs_m[m];
        tick();
        exp_start = 0;
        if (lat > 0) begin
          repeat (lat - 1) begin core_result = rnd512(); tick(); end
          core_result = ld[OPW-1:0]; core_done = 1'b1;
          tick();
          core_done = 1'b0; core_result = rnd512();
          exp_cnt = 24'(lat);
          tick();
          exp_done = 1; regs_m[d] = ld[OPW-1:0];
        end else begin
          repeat (TO - 1) tick();
          tick();
          exp_done = 1; exp_clear = 1; exp_err = 3; exp_cnt = 24'(TO);
          tick();
          exp_clear = 0;
        end
      end
      default: begin  // CLEAR
        exp_clear = 1;
        tick();
        exp_clear = 0; exp_done = 1;
      end
    endcase
    finish_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TX-1:0] beat;
    logic [3:0] op, d, a, b, m;
    int r;
    for (int i = 0; i < NR; i++) regs_m[i] = '0;
    mon_en = 1;
    #1;
    chk("rst_done",  TX'(fpga_to_arm_done), '0);
    chk("rst_clear", TX'(core_clear), TX'(1'b1));
    chk("rst_data",  fpga_to_arm_data, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; exp_clear = 0;
    tick();

    // LOAD with wrap: slice0 -> reg7, slice1 -> reg0; then STORE back
    beat = {{128{4'h2}}, {128{4'h1}}};
    run_cmd(4'd1, 4'd7, 0, 0, 0, 0, beat);
    chk("model_reg7", TX'(regs_m[7]), TX'({128{4'h1}}));
    chk("model_reg0", TX'(regs_m[0]), TX'({128{4'h2}}));
    lit_en = 1; lit_data = beat;
    run_cmd(4'd2, 4'd7, 0, 0, 0, 0, '0);
    lit_en = 0;

    // MULT 0,1,2 -> 3, latency 20, result 0xABC
    run_cmd(4'd1, 4'd1, 0, 0, 0, 0, {rnd512(), rnd512()});
    run_cmd(4'd3, 4'd3, 4'd0, 4'd1, 4'd2, 20, TX'(12'hABC));
    chk("mult_status_lit", TX'(fpga_to_arm_status), TX'(32'd20));
    lit_en = 1; lit_data = {regs_m[4], 512'hABC};
    run_cmd(4'd2, 4'd3, 0, 0, 0, 0, '0);
    lit_en = 0;

    // Bad opcode, then NOP clears error
    run_cmd(4'hF, 4'd3, 0, 0, 0, 0, '0);
    chk("badop_err_lit", TX'(fpga_to_arm_status[31:28]), TX'(4'd1));
    run_cmd(4'd0, 0, 0, 0, 0, 0, '0);
    chk("nop_err_lit", TX'(fpga_to_arm_status[31:28]), TX'(4'd0));

    // Timeout, latency boundaries, bad index, CLEAR
    run_cmd(4'd3, 4'd3, 4'd1, 4'd0, 4'd7, 0, '0);
    chk("timeout_status_lit", TX'(fpga_to_arm_status), TX'({4'd3, 4'd0, 24'd64}));
    run_cmd(4'd2, 4'd3, 0, 0, 0, 0, '0);
    run_cmd(4'd3, 4'd5, 4'd3, 4'd3, 4'd0, TO, {rnd512(), rnd512()});
    run_cmd(4'd3, 4'd6, 4'd5, 4'd7, 4'd6, 1, {rnd512(), rnd512()});
    run_cmd(4'd1, 4'd9, 0, 0, 0, 0, '0);
    run_cmd(4'd3, 4'd2, 4'd1, 4'd12, 4'd0, 5, '0);
    run_cmd(4'd4, 0, 0, 0, 0, 0, '0);

    // Randomized command stream
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      d = 4'($urandom_range(0, 7)); a = 4'($urandom_range(0, 7));
      b = 4'($urandom_range(0, 7)); m = 4'($urandom_range(0, 7));
      case (r)
        0: op = 4'd0;
        1, 2: op = 4'd1;
        3: op = 4'd2;
        4, 5, 9: op = 4'd3;
        6: op = 4'd4;
        7: op = 4'($urandom_range(5, 15));
        default: begin
          op = 4'($urandom_range(1, 3));
          if (op == 4'd3 && $urandom_range(0, 1) == 1) a = 4'($urandom_range(8, 15));
          else d = 4'($urandom_range(8, 15));
        end
      endcase
      run_cmd(op, d, a, b, m,
              (r == 9 && $urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, TO)),
              {rnd512(), rnd512()});
    end

    // Reset in the middle of WAIT, then a late core_done
    arm_to_fpga_cmd = {12'd0, 4'd2, 4'd1, 4'd0, 4'd6, 4'd3};
    arm_to_fpga_cmd_valid = 1'b1;
    tick();
    arm_to_fpga_cmd_valid = 1'b0;
    exp_err = 0; exp_start = 1; ops_on = 1;
    exp_a = regs_m[0]; exp_b = regs_m[1]; exp_m = regs_m[2];
    tick();
    exp_start = 0;
    repeat (5) tick();
    reset = 1'b1;
    exp_clear = 1; exp_done = 0; exp_err = 0; exp_cnt = 0;
    exp_a = '0; exp_b = '0; exp_m = '0;
    for (int i = 0; i < NR; i++) regs_m[i] = '0;
    #1;
    chk("midrst_clear",  TX'(core_clear), TX'(1'b1));
    chk("midrst_status", TX'(fpga_to_arm_status), '0);
    chk("midrst_core_a", TX'(core_a), '0);
    chk("midrst_leds",   TX'(leds), '0);
    tick(); tick();
    reset = 1'b0; exp_clear = 0;
    core_result = rnd512(); core_done = 1'b1;
    tick();
    core_done = 1'b0;
    run_cmd(4'd2, 4'd6, 0, 0, 0, 0, '0);
    run_cmd(4'd3, 4'd1, 4'd6, 4'd7, 4'd0, 3, {rnd512(), rnd512()});
    run_cmd(4'd2, 4'd0, 0, 0, 0, 0, '0);

    tick();
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
